ama_riscv_mem_arbiter: RTL
==========================

// Module: ama_riscv_mem_arbiter
// PURPOSE
//  Two-requester arbiter sharing one synchronous single-port memory port
//  (IMEM/DMEM port A) between core data port (C) and host/loader port (H).
//  Round-robin on contention; H can lock the port for a bounded burst
//  (program load).
//  Sits between core MEM stage / host loader and the memory macro.
//  c_stall feeds the core pipeline control.
// PARAMETERS
//  ADDR_W    14   word address width
//  DATA_W    32   data width (byte-enable width = DATA_W/8)
//  MAX_LOCK  16   max cycles H may hold lock; >=1; cnt width $clog2(MAX_LOCK+1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  c_req      in   1        core request; held stable until c_gnt
//  c_we       in   DATA_W/8 core byte write enables; 0 = read
//  c_addr     in   ADDR_W   core word address
//  c_wdata    in   DATA_W   core write data
//  c_gnt      out  1        core request accepted this cycle
//  c_stall    out  1        c_req & ~c_gnt
//  c_rvalid   out  1        core read data valid
//  c_rdata    out  DATA_W   core read data; 0 when ~c_rvalid
//  h_req/h_we/h_addr/h_wdata  in   host equivalents of c_*
//  h_lock     in   1        host requests exclusive port ownership
//  h_gnt, h_rvalid, h_rdata   out  host equivalents of c_*
//  mem_en     out  1        memory enable
//  mem_we     out  DATA_W/8 memory byte write enables
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
//  mem_rdata  in   DATA_W   memory read data, valid 1 cycle after mem_en read
// BEHAVIOUR
//  - Reset: state=IDLE, last_gnt=H (C wins first tie), lock_cnt=0,
//    rd_owner_q=none; during rst: c_gnt=h_gnt=mem_en=0, mem_we=0,
//    mem_addr=0, mem_wdata=0, c_rvalid=h_rvalid=0, c_rdata=h_rdata=0.
//  - Grants combinational, same cycle as req; at most one gnt per cycle.
//    mem_* driven from the granted requester; mem_en=c_gnt|h_gnt; all 0
//    when no grant.
//  - IDLE, one req: grant it. Both: grant != last_gnt.
//    last_gnt <= winner on every grant.
//  - IDLE -> LOCKED when h_gnt & h_lock; lock_cnt <= 1.
//  - LOCKED: c_gnt=0 always. h_gnt=h_req. lock_cnt increments every LOCKED
//    cycle, with or without h_req.
//  - LOCKED -> IDLE when ~h_lock, or when lock_cnt==MAX_LOCK at a clock edge.
//    Exit cycle: no grant change; last_gnt=H.
//    Next IDLE cycle grants C if c_req (H may not re-lock first).
//    lock_cnt <= 0 on exit.
//  - Reads (granted, we==0): rd_owner_q registers the owner. Next cycle
//    <x>_rvalid=1, <x>_rdata=mem_rdata. Latency 1. Writes: no rvalid.
//  - Back-to-back reads from alternating owners return in grant order,
//    1 per cycle.
//  - rst mid-operation: pending rvalid dropped (0 next cycle); lock released.
//  - Requester must not change addr/we/wdata while req & ~gnt; not checked.
// TESTING
//  1. Reset: rst=1 with c_req=h_req=1 -> all outputs 0; after release,
//     first tie grants C.
//  2. Both req reads every cycle (C addr 0x10, H addr 0x20) -> gnt
//     alternates C,H,C,H; each rvalid 1 cycle after grant, data matches
//     memory.
//  3. C write c_we=4'b0011, addr 0x5, data 0xAABBCCDD -> mem_we=0011 same
//     cycle; no c_rvalid; readback returns low halfword updated.
//  4. H lock burst, h_lock=1, h_req=1 for 20 cycles, c_req=1 -> H granted
//     16 cycles, C stalled (c_stall=1), then exit; C granted next cycle.
//  5. h_lock dropped after 3 words -> exit to IDLE next edge, lock_cnt=0;
//     C served next cycle.
//  6. rst asserted 1 cycle after H read grant -> h_rvalid stays 0, state
//     IDLE, last_gnt=H.

Source files
------------

// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter: round-robin core/host arbiter for one sync memory port with host burst lock
//   ports: clk, rst (sync, active-high)
//          c_req/c_we/c_addr/c_wdata -> c_gnt/c_stall/c_rvalid/c_rdata  (core)
//          h_req/h_we/h_addr/h_wdata/h_lock -> h_gnt/h_rvalid/h_rdata   (host)
//          mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory (1-cycle read latency)
module ama_riscv_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic [DATA_W/8-1:0] c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_gnt,
  output logic                c_stall,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                h_req,
  input  logic [DATA_W/8-1:0] h_we,
  input  logic [ADDR_W-1:0]   h_addr,
  input  logic [DATA_W-1:0]   h_wdata,
  input  logic                h_lock,
  output logic                h_gnt,
  output logic                h_rvalid,
  output logic [DATA_W-1:0]   h_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state;
  logic             last_gnt;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rd_owner_q;
  logic             lock_last;
  // last_gnt: 1 = host won last, so the core wins the next tie
  always_comb begin
    c_gnt     = !rst && state == IDLE && c_req && (!h_req || last_gnt);
    h_gnt     = !rst && h_req && (state == LOCKED || !c_req || !last_gnt);
    c_stall   = c_req && !c_gnt;
    mem_en    = c_gnt || h_gnt;
    mem_we    = c_gnt ? c_we : h_gnt ? h_we : '0;
    mem_addr  = c_gnt ? c_addr : h_gnt ? h_addr : '0;
    mem_wdata = c_gnt ? c_wdata : h_gnt ? h_wdata : '0;
    c_rvalid  = !rst && rd_owner_q[0];
    h_rvalid  = !rst && rd_owner_q[1];
    c_rdata   = c_rvalid ? mem_rdata : '0;
    h_rdata   = h_rvalid ? mem_rdata : '0;
    // the lock-entry grant counts as the first held cycle, so the final LOCKED cycle sees MAX_LOCK-1
    lock_last = lock_cnt >= CNT_W'(MAX_LOCK - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      lock_cnt   <= '0;
      rd_owner_q <= '0;
    end else begin
      rd_owner_q <= {h_gnt && h_we == '0, c_gnt && c_we == '0};
      if (c_gnt) last_gnt <= 1'b0;
      else if (h_gnt) last_gnt <= 1'b1;
      if (state == IDLE && h_gnt && h_lock) begin
        state    <= LOCKED;
        lock_cnt <= CNT_W'(1);
      end else if (state == LOCKED) begin
        if (!h_lock || lock_last) begin
          state    <= IDLE;
          lock_cnt <= '0;
          last_gnt <= 1'b1;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end
  end
endmodule
